oddr_tx_seq: RTL

ODDR_TX_SEQ -- requirements
Module: oddr_tx_seq

---
 rtl/oddr_tx_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/oddr_tx_seq.sv
// oddr_tx_seq: serializes a parallel word into D1/D2 bit pairs for an ODDR,
// LSB pair first, with optional idle gap, freeze and reset-hold handling.
module oddr_tx_seq #(
  parameter int   DATA_WIDTH = 8,
  parameter int   GAP_CYCLES = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic                  C,
  input  logic                  R,
  input  logic                  ENABLE,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic                  ODDR_D1,
  output logic                  ODDR_D2,
  output logic                  ODDR_CE,
  output logic                  ODDR_R,
  output logic                  FRAME,
  output logic                  BUSY
);

  localparam int BEATS = DATA_WIDTH / 2;
  localparam int BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
  localparam logic NO_GAP = (GAP_CYCLES == 0);
  localparam logic USE_GAP = (GAP_CYCLES > 1);
  // The IDLE cycle that re-arms IN_READY is itself one of the idle
  // cycles, so GAP only has to cover GAP_CYCLES-1 of them.
  localparam logic [7:0] GAP_LOAD =
    USE_GAP ? 8'(GAP_CYCLES - 2) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [7:0]            gap_q, gap_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
  logic                  d1_q, d1_d;
  logic                  d2_q, d2_d;
  logic                  frame_q, frame_d;
  logic                  busy_q, busy_d;
  logic                  ce_q, ce_d;
  logic                  rr_q, rr_d;
  logic                  hold_q, hold_d;
  logic                  accept;
  logic                  load;
  logic                  adv;
  logic                  stop;

  assign ODDR_D1 = d1_q;
  assign ODDR_D2 = d2_q;
  assign ODDR_CE = ce_q;
  assign ODDR_R  = rr_q;
  assign FRAME   = frame_q;
  assign BUSY    = busy_q;

  // Ready decode from registered state and ENABLE only.
  always_comb begin
    IN_READY = 1'b0;
    unique case (state_q)
      S_IDLE:  IN_READY = ENABLE & ~rr_q;
      S_SHIFT: IN_READY = ENABLE & NO_GAP & (beat_q == BEAT_LAST);
      default: IN_READY = 1'b0;
    endcase
  end

  assign accept = IN_VALID & IN_READY;

  // Next-state: everything holds unless enabled and out of reset hold.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    gap_d   = gap_q;
    sreg_d  = sreg_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    frame_d = frame_q;
    load    = 1'b0;
    adv     = 1'b0;
    stop    = 1'b0;
    hold_d  = 1'b0;
    rr_d    = hold_q;
    ce_d    = ~hold_q & ENABLE;
    if (ENABLE && !rr_q) begin
      unique case (state_q)
        S_IDLE: begin
          load = accept;
        end
        S_SHIFT: begin
          if (beat_q != BEAT_LAST) begin
            adv = 1'b1;
          end else if (accept) begin
            load = 1'b1;
          end else begin
            stop = 1'b1;
          end
        end
        S_GAP: begin
          if (gap_q == 8'd0) begin
            state_d = S_IDLE;
          end else begin
            gap_d = gap_q - 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    if (load) begin
      state_d = S_SHIFT;
      beat_d  = '0;
      sreg_d  = IN_DATA >> 2;
      d1_d    = IN_DATA[0];
      d2_d    = IN_DATA[1];
      frame_d = 1'b1;
    end else if (adv) begin
      beat_d  = beat_q + BW'(1);
      sreg_d  = sreg_q >> 2;
      d1_d    = sreg_q[0];
      d2_d    = sreg_q[1];
    end else if (stop) begin
      state_d = USE_GAP ? S_GAP : S_IDLE;
      beat_d  = '0;
      gap_d   = GAP_LOAD;
      d1_d    = IDLE_LEVEL;
      d2_d    = IDLE_LEVEL;
      frame_d = 1'b0;
    end
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge C) begin
    if (!R) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      gap_q   <= 8'd0;
      sreg_q  <= '0;
      d1_q    <= IDLE_LEVEL;
      d2_q    <= IDLE_LEVEL;
      frame_q <= 1'b0;
      busy_q  <= 1'b0;
      ce_q    <= 1'b0;
      rr_q    <= 1'b1;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      gap_q   <= gap_d;
      sreg_q  <= sreg_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      frame_q <= frame_d;
      busy_q  <= busy_d;
      ce_q    <= ce_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
    end
  end

endmodule
